// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: bus width, counter
// width and the 2-bit FSM state encoding.
package inst_fetch_unit_pkg;

    // Width of the address, instruction and memory data buses.
    localparam int WORD_SIZE = 16;

    // Width of the completed-fetch counter.
    localparam int COUNT_W = 16;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// One-entry instruction buffer: a tag (fetch address), its data word and a
// valid bit. It is refilled on every completed memory fetch and cleared by an
// explicit invalidate. The lookup is combinational, and an invalidate in the
// same cycle forces a miss.
module fetch_buf #(
    parameter int WORD_SIZE = inst_fetch_unit_pkg::WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inval,
    input  logic                 fill,
    input  logic [WORD_SIZE-1:0] fill_tag,
    input  logic [WORD_SIZE-1:0] fill_data,
    input  logic [WORD_SIZE-1:0] lookup_addr,
    output logic                 hit,
    output logic [WORD_SIZE-1:0] hit_data
);

    logic                 valid_q;
    logic [WORD_SIZE-1:0] tag_q;
    logic [WORD_SIZE-1:0] data_q;

    // Entry storage: invalidate wins over a fill landing in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            if (fill) begin
                valid_q <= 1'b1;
                tag_q   <= fill_tag;
                data_q  <= fill_data;
            end
            if (inval) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Hit check against the stored tag; a same-cycle invalidate forces a miss.
    always_comb begin
        hit      = valid_q && !inval && (tag_q == lookup_addr);
        hit_data = data_q;
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit. It latches the PC on a fetch request, strobes
// memory until read data is valid, loads the instruction register, pulses
// fetch_done and counts completed fetches.
// Optional feature macro: FETCH_BUF_EN adds a one-entry fetch buffer
// (sub-module fetch_buf) and the buf_inval input. A hit on that buffer skips
// the memory request.
//
// Handshake: fetch_req is only looked at in IDLE. readM is held high, with a
// stable address, for every REQ cycle. The first cycle that inputReady is
// sampled high in REQ transfers data. fetch_done is a single-cycle valid
// pulse for the instruction output and has no ready, so it cannot stall.
// fetch_abort cancels whatever is in flight, and reset overrides everything.
module inst_fetch_unit #(
    parameter int WORD_SIZE = inst_fetch_unit_pkg::WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] inst_addr,
    input  logic                 fetch_req,
    input  logic                 fetch_abort,
    output logic                 readM,
    output logic [WORD_SIZE-1:0] address,
    input  logic [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    output logic [WORD_SIZE-1:0] instruction,
    output logic                 fetch_done,
    output logic                 busy,
    output logic [15:0]          fetch_count,
`ifdef FETCH_BUF_EN
    input  logic                 buf_inval,
`endif
    output logic [1:0]           state_dbg
);

    import inst_fetch_unit_pkg::*;

    fetch_state_t         state_q;
    fetch_state_t         state_d;
    logic [WORD_SIZE-1:0] address_q;
    logic [WORD_SIZE-1:0] instruction_q;
    logic [COUNT_W-1:0]   fetch_count_q;

    logic                 start;
    logic                 mem_fill;
    logic                 buf_load;
    logic                 count_en;
    logic                 buf_hit;
    logic [WORD_SIZE-1:0] buf_rdata;

`ifdef FETCH_BUF_EN
    fetch_buf #(
        .WORD_SIZE (WORD_SIZE)
    ) u_fetch_buf (
        .clk         (clk),
        .reset       (reset),
        .inval       (buf_inval),
        .fill        (mem_fill),
        .fill_tag    (address_q),
        .fill_data   (data),
        .lookup_addr (inst_addr),
        .hit         (buf_hit),
        .hit_data    (buf_rdata)
    );
`else
    assign buf_hit   = 1'b0;
    assign buf_rdata = '0;
`endif

    // Qualified events: accepted request, memory transfer, buffer hit, retire.
    always_comb begin
        start    = (state_q == ST_IDLE) && fetch_req && !fetch_abort;
        mem_fill = (state_q == ST_REQ) && inputReady && !fetch_abort;
        buf_load = start && buf_hit;
        count_en = (state_q == ST_DONE) && !fetch_abort;
    end

    // State register; reset has priority over abort and every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort always lands in IDLE, so abort beats inputReady.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = buf_hit ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (fetch_abort) begin
                    state_d = ST_IDLE;
                end else if (inputReady) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: address latched on accept, IR loaded from memory or buffer,
    // and the counter advances when DONE retires without an abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            address_q     <= '0;
            instruction_q <= '0;
            fetch_count_q <= '0;
        end else begin
            if (start) begin
                address_q <= inst_addr;
            end
            if (mem_fill) begin
                instruction_q <= data;
            end else if (buf_load) begin
                instruction_q <= buf_rdata;
            end
            if (count_en) begin
                fetch_count_q <= fetch_count_q + 1'b1;
            end
        end
    end

    // Outputs decoded from state; an abort or reset in DONE suppresses the pulse.
    always_comb begin
        readM       = (state_q == ST_REQ);
        busy        = (state_q != ST_IDLE);
        fetch_done  = (state_q == ST_DONE) && !fetch_abort && !reset;
        address     = address_q;
        instruction = instruction_q;
        fetch_count = fetch_count_q;
        state_dbg   = state_q;
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit. It contains a transaction-level reference
// model (IR value, completed count, buffer contents) and a scoreboard queue
// filled by the driver. A monitor drains that queue on every fetch_done.
module tb_inst_fetch_unit;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic [W-1:0] inst_addr;
  logic         fetch_req;
  logic         fetch_abort;
  logic         readM;
  logic [W-1:0] address;
  logic [W-1:0] data;
  logic         inputReady;
  logic [W-1:0] instruction;
  logic         fetch_done;
  logic         busy;
  logic [15:0]  fetch_count;
  logic         buf_inval;
  logic [1:0]   state_dbg;

  inst_fetch_unit #(.WORD_SIZE(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .inst_addr   (inst_addr),
    .fetch_req   (fetch_req),
    .fetch_abort (fetch_abort),
    .readM       (readM),
    .address     (address),
    .data        (data),
    .inputReady  (inputReady),
    .instruction (instruction),
    .fetch_done  (fetch_done),
    .busy        (busy),
    .fetch_count (fetch_count),
`ifdef FETCH_BUF_EN
    .buf_inval   (buf_inval),
`endif
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and reference model
  logic [W-1:0] exp_q[$];
  logic [15:0]  exp_cnt_q[$];
  logic [W-1:0] exp_instr;
  logic [15:0]  exp_count;
  logic         exp_readm;
  logic         exp_busy;
  logic [W-1:0] cur_addr;
  logic         m_valid;
  logic [W-1:0] m_tag;
  logic [W-1:0] m_data;
  int           rd_cycles;
  bit           mon_en;
  bit           cnt_pending;
  logic [15:0]  cnt_pending_val;
  int           n_tests;
  int           n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: samples on the falling edge, pops the scoreboard on fetch_done
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (cnt_pending) begin
        chk("count_after_done", fetch_count, cnt_pending_val);
        cnt_pending = 0;
      end
      if (mon_en) begin
        chk("readM", readM, exp_readm);
        chk("busy", busy, exp_busy);
        if (readM) begin
          rd_cycles++;
          chk("address_stable", address, cur_addr);
        end
        if (fetch_done) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_fetch_done: got 1, expected 0 at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("instruction", instruction, e);
            cnt_pending     = 1;
            cnt_pending_val = exp_cnt_q.pop_front();
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record a completed fetch in the model and the scoreboard.
  task automatic expect_done(input logic [W-1:0] d);
    exp_instr = d;
    exp_count = exp_count + 16'd1;
    exp_q.push_back(d);
    exp_cnt_q.push_back(exp_count);
  endtask

  // Driver for one fetch.
  // abort_at: -1 means no abort, -2 means abort together with the request,
  // and k >= 0 means abort on REQ cycle k. Memory answers on REQ cycle lat.
  task automatic do_fetch(input logic [W-1:0] addr, input logic [W-1:0] d, input int lat,
                          input int abort_at, input bit hold, input bit inval);
    bit hit;
    hit = 0;
    rd_cycles = 0;
`ifdef FETCH_BUF_EN
    if (inval) m_valid = 0;
    hit = m_valid && (m_tag == addr);
    buf_inval = inval;
`endif
    inst_addr = addr;
    fetch_req = 1;
    cur_addr  = addr;
    if (abort_at == -2) begin
      fetch_abort = 1;
      tick();
      fetch_abort = 0;
      fetch_req   = 0;
      buf_inval   = 0;
      tick();
      chk("idle_abort_rd_cycles", rd_cycles, 0);
      chk("idle_abort_count", fetch_count, exp_count);
      return;
    end
    if (hit) begin
      expect_done(m_data);
      tick();
      buf_inval = 0;
      exp_busy  = 1;
      exp_readm = 0;
      if (!hold) fetch_req = 0;
      tick();
      fetch_req = 0;
      exp_busy  = 0;
      chk("hit_rd_cycles", rd_cycles, 0);
    end else begin
      tick();
      buf_inval = 0;
      exp_busy  = 1;
      exp_readm = 1;
      for (int i = 0; i <= lat; i++) begin
        if (hold) inst_addr = addr ^ 16'h0030;
        else fetch_req = 0;
        if (i == abort_at) begin
          fetch_abort = 1;
          inputReady  = 1'($urandom_range(0, 1));
          data        = W'($urandom);
          tick();
          fetch_abort = 0;
          fetch_req   = 0;
          exp_busy    = 0;
          exp_readm   = 0;
          inputReady  = 1;
          data        = 16'hFFFF;
          tick();
          inputReady = 0;
          chk("abort_instr", instruction, exp_instr);
          chk("abort_count", fetch_count, exp_count);
          chk("abort_rd_cycles", rd_cycles, abort_at + 1);
          return;
        end
        inputReady = (i == lat);
        data       = (i == lat) ? d : W'($urandom);
        if (i == lat) begin
          expect_done(d);
          m_valid = 1;
          m_tag   = addr;
          m_data  = d;
        end
        tick();
      end
      exp_readm  = 0;
      inputReady = 1'($urandom_range(0, 1));
      data       = W'($urandom);
      tick();
      fetch_req  = 0;
      inputReady = 0;
      exp_busy   = 0;
      chk("miss_rd_cycles", rd_cycles, lat + 1);
    end
    chk("fetch_done_seen", exp_q.size(), 0);
    exp_q.delete();
    exp_cnt_q.delete();
  endtask

  // Idle cycles with stray inputReady (and buffer invalidates when present).
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      inputReady = 1'($urandom_range(0, 1));
      data       = W'($urandom);
`ifdef FETCH_BUF_EN
      buf_inval = ($urandom_range(0, 3) == 0);
      if (buf_inval) m_valid = 0;
`endif
      tick();
    end
    inputReady = 0;
    buf_inval  = 0;
  endtask

  initial begin
    logic [W-1:0] a;
    int sel;
    int lat;
    int ab;
    n_tests = 0;
    n_fail = 0;
    mon_en = 0;
    cnt_pending = 0;
    reset = 1;
    inst_addr = '0;
    fetch_req = 0;
    fetch_abort = 0;
    data = '0;
    inputReady = 0;
    buf_inval = 0;
    exp_instr = '0;
    exp_count = '0;
    exp_readm = 0;
    exp_busy = 0;
    cur_addr = '0;
    m_valid = 0;
    m_tag = '0;
    m_data = '0;
    rd_cycles = 0;

    // reset values
    tick();
    tick();
    chk("rst_readM", readM, 0);
    chk("rst_address", address, 0);
    chk("rst_instruction", instruction, 0);
    chk("rst_fetch_done", fetch_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fetch_count", fetch_count, 0);
    reset = 0;
    mon_en = 1;
    tick();

    // memory answers on the 3rd REQ cycle
    do_fetch(16'h0010, 16'hA123, 2, -1, 0, 1);
    chk("basic_instr", instruction, 16'hA123);
    chk("basic_count", fetch_count, 16'd1);
    chk("basic_address", address, 16'h0010);

    // abort on the 2nd REQ cycle, late data 0xFFFF ignored
    do_fetch(16'h0030, 16'h5555, 5, 1, 0, 1);
    chk("abort_keeps_instr", instruction, 16'hA123);

    // request held high while the PC moves to 0x0020
    do_fetch(16'h0010, 16'hBEEF, 1, -1, 1, 1);
    chk("hold_address", address, 16'h0010);
    chk("hold_count", fetch_count, 16'd2);
    idle_gap(2);
    chk("hold_no_extra_fetch", fetch_count, 16'd2);

    // abort together with the request in IDLE
    do_fetch(16'h0070, 16'h1111, 0, -2, 0, 1);

    // counter wrap
    force dut.fetch_count_q = 16'hFFFE;
    #1;
    release dut.fetch_count_q;
    exp_count = 16'hFFFE;
    chk("count_preset", fetch_count, 16'hFFFE);
    do_fetch(16'h0200, 16'h0F0F, 0, -1, 0, 1);
    chk("count_ffff", fetch_count, 16'hFFFF);
    do_fetch(16'h0202, 16'hF0F0, 0, -1, 0, 1);
    chk("count_wrap", fetch_count, 16'h0000);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 2);
      a = (sel == 0) ? 16'h0040 : (sel == 1) ? 16'h0080 : (16'h1000 | W'($urandom_range(0, 255)));
      lat = $urandom_range(0, 3);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat) : -1;
      if ($urandom_range(0, 9) == 0) ab = -2;
      do_fetch(a, W'($urandom), lat, ab, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
      idle_gap($urandom_range(0, 2));
      chk("rand_count", fetch_count, exp_count);
      chk("rand_instr", instruction, exp_instr);
    end

`ifdef FETCH_BUF_EN
    // buffer hit, then invalidate forces memory again
    do_fetch(16'h0040, 16'h1234, 1, -1, 0, 1);
    do_fetch(16'h0040, 16'h0000, 0, -1, 0, 0);
    chk("buf_hit_instr", instruction, 16'h1234);
    buf_inval = 1;
    m_valid = 0;
    tick();
    buf_inval = 0;
    do_fetch(16'h0040, 16'h5678, 0, -1, 0, 0);
    chk("buf_refetch_instr", instruction, 16'h5678);
`endif

    // reset coinciding with inputReady in REQ
    inst_addr = 16'h0050;
    cur_addr = 16'h0050;
    fetch_req = 1;
    buf_inval = 1;
    rd_cycles = 0;
    tick();
    fetch_req = 0;
    buf_inval = 0;
    exp_busy = 1;
    exp_readm = 1;
    inputReady = 1;
    data = 16'hCAFE;
    reset = 1;
    tick();
    reset = 0;
    inputReady = 0;
    exp_busy = 0;
    exp_readm = 0;
    exp_instr = '0;
    exp_count = '0;
    m_valid = 0;
    chk("rst2_readM", readM, 0);
    chk("rst2_address", address, 0);
    chk("rst2_instruction", instruction, 0);
    chk("rst2_fetch_done", fetch_done, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_fetch_count", fetch_count, 0);
    tick();
    chk("rst2_count_hold", fetch_count, 0);
    chk("rst2_no_done_pending", exp_q.size(), 0);

    // fetch after reset still works
    do_fetch(16'h0060, 16'h7E57, 0, -1, 0, 1);
    chk("post_rst_count", fetch_count, 16'd1);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, width of the address, instruction and memory data buses.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port inst_addr  input  WORD_SIZE  fetch address supplied by the program counter.
REQ-005 SHALL have port fetch_req  input  1  control-unit request to fetch from inst_addr; sampled only in IDLE.
REQ-006 SHALL have port fetch_abort  input  1  cancels any outstanding fetch.
REQ-007 SHALL have port readM  output  1  memory read strobe.
REQ-008 SHALL have port address  output  WORD_SIZE  memory address.
REQ-009 SHALL have port data  input  WORD_SIZE  memory read data.
REQ-010 SHALL have port inputReady  input  1  memory read-data-valid.
REQ-011 SHALL have port instruction  output  WORD_SIZE  last fetched instruction (IR).
REQ-012 SHALL have port fetch_done  output  1  one-cycle pulse; instruction valid.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port fetch_count  output  16  number of completed fetches.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, DONE.
REQ-016 IDLE with fetch_req=1 and fetch_abort=0 SHALL latch inst_addr into address and go to REQ.
REQ-017 In REQ, readM SHALL be 1 and address SHALL be held stable until inputReady is sampled high.
REQ-018 In REQ with inputReady=1, data SHALL be latched into instruction and the FSM SHALL go to DONE.
REQ-019 In DONE, fetch_done SHALL be 1 for exactly one cycle; fetch_count SHALL increment by 1 (wrapping 0xFFFF->0x0000); FSM SHALL return to IDLE.
REQ-020 Minimum latency SHALL be fetch_req edge -> fetch_done asserted 2 cycles later when inputReady is already high on the first REQ cycle.
REQ-021 fetch_req outside IDLE SHALL be ignored; no queuing.
REQ-022 fetch_abort=1 in any state SHALL return the FSM to IDLE next cycle, deassert readM, suppress fetch_done, and leave instruction and fetch_count unchanged.
REQ-023 fetch_abort and inputReady in the same REQ cycle SHALL resolve as abort: data discarded.
REQ-024 inputReady while not in REQ SHALL be ignored.
REQ-025 readM SHALL be 0 in IDLE and DONE.

Reset
REQ-026 reset SHALL take priority over all inputs, including fetch_abort.
REQ-027 On reset: state=IDLE, readM=0, address=0, instruction=0, fetch_done=0, busy=0, fetch_count=0; the buffer is invalidated when present.
REQ-028 Reset asserted mid-fetch SHALL abandon the fetch with no fetch_done, including if inputReady coincides.

Configuration
REQ-029 Macro FETCH_BUF_EN SHALL, when defined, add a one-entry buffer (tag address, data, valid) filled on every completed memory fetch.
REQ-030 With FETCH_BUF_EN defined, IDLE + fetch_req where inst_addr equals a valid tag SHALL go directly to DONE with no readM; instruction SHALL be loaded from the buffer and fetch_count SHALL increment.
REQ-031 With FETCH_BUF_EN defined, input buf_inval (1 bit) SHALL clear valid; a hit check in the same cycle SHALL miss.
REQ-032 Without FETCH_BUF_EN, the buffer and buf_inval SHALL be absent, and every fetch SHALL use memory.

Structure
REQ-033 WORD_SIZE and the FSM state encodings (2-bit) SHALL reside in the shared opcodes header/package.
REQ-034 The buffer SHALL be a sub-module, fetch_buf, instantiated only under FETCH_BUF_EN.

Verification
REQ-035 reset; inst_addr=0x0010, fetch_req pulse, inputReady high on the 3rd REQ cycle with data=0xA123 -> readM=1 for 3 cycles, address=0x0010, instruction=0xA123, one fetch_done pulse, fetch_count=1.
REQ-036 fetch_abort on the 2nd REQ cycle, then inputReady with data=0xFFFF -> no fetch_done, instruction unchanged, readM=0 after the abort.
REQ-037 fetch_req held high during REQ with inst_addr changing 0x0010->0x0020 -> address stays 0x0010; exactly one fetch.
REQ-038 fetch_count preset to 0xFFFF via 65535 fetches (or force), then one fetch -> fetch_count=0x0000.
REQ-039 FETCH_BUF_EN: fetch 0x0040 (data 0x1234), then re-fetch 0x0040 -> no readM, fetch_done 1 cycle after the request, instruction=0x1234; after buf_inval, re-fetch -> readM asserted.
REQ-040 reset asserted in the same cycle as inputReady in REQ -> no fetch_done; all outputs take their reset values next cycle.
